// File: rtl/game_draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : game_draw_pkg                                                     |
// | Brief  : State/level encodings, enable bit map and default phase lengths   |
// |          for the game draw sequencer.                                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package game_draw_pkg;

  typedef enum logic [2:0] {
    S_CLR0 = 3'd0,
    S_GRID = 3'd1,
    S_MENU = 3'd2,
    S_LVL  = 3'd3,
    S_PLAY = 3'd4,
    S_NUM  = 3'd5,
    S_CLR1 = 3'd6,
    S_GAP  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'b00,
    LVL_EZ     = 2'b01,
    LVL_NORMAL = 2'b10,
    LVL_HARD   = 2'b11
  } level_e;

  localparam int c_CLEAR_CYCLES = 19200;
  localparam int c_GRID_CYCLES  = 4096;
  localparam int c_NUM_CYCLES   = 4096;
  localparam int c_CW           = 15;

  // Bit positions inside the one-hot enable vector
  localparam int c_EN_GRID   = 0;
  localparam int c_EN_EZ     = 1;
  localparam int c_EN_NORMAL = 2;
  localparam int c_EN_HARD   = 3;
  localparam int c_EN_NUM    = 4;
  localparam int c_EN_CLEAR  = 5;

  function automatic logic [5:0] draw_en(state_e s, level_e l);
    logic [5:0] en;
    en = '0;
    case (s)
      S_CLR0, S_CLR1: en[c_EN_CLEAR] = 1'b1;
      S_GRID:         en[c_EN_GRID]  = 1'b1;
      S_NUM:          en[c_EN_NUM]   = 1'b1;
      S_LVL: begin
        case (l)
          LVL_EZ:     en[c_EN_EZ]     = 1'b1;
          LVL_NORMAL: en[c_EN_NORMAL] = 1'b1;
          LVL_HARD:   en[c_EN_HARD]   = 1'b1;
          default:    en = '0;
        endcase
      end
      default: en = '0;
    endcase
    return en;
  endfunction

  // Idle/draw state entered once the gap that follows a draw phase ends
  function automatic state_e after_phase(state_e s);
    case (s)
      S_CLR0, S_CLR1: return S_GRID;
      S_GRID:         return S_MENU;
      default:        return S_PLAY;
    endcase
  endfunction

  function automatic logic is_busy(state_e s);
    return (s != S_MENU) && (s != S_PLAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_draw_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : game_draw_sequencer_if                                            |
// | Brief  : Control inputs from game logic and phase enables to the datapath. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface game_draw_sequencer_if;
  logic       level_valid;
  logic [1:0] level;
  logic       redraw_req;
  logic       game_over;
  logic       drawGrid;
  logic       drawEZ;
  logic       drawNORMAL;
  logic       drawHARD;
  logic       drawNum;
  logic       clear;
  logic       plot;
  logic       busy;
  logic       phase_done;

  modport master (
    output level_valid, level, redraw_req, game_over,
    input  drawGrid, drawEZ, drawNORMAL, drawHARD, drawNum, clear, plot, busy, phase_done
  );

  modport slave (
    input  level_valid, level, redraw_req, game_over,
    output drawGrid, drawEZ, drawNORMAL, drawHARD, drawNum, clear, plot, busy, phase_done
  );
endinterface
`default_nettype wire

// File: rtl/game_draw_sequencer_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : phase_timer                                                       |
// | Brief  : Counts 0..N-1 while a phase enable is high; flags the last cycle. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module phase_timer #(
  parameter int CW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  input  logic [CW-1:0] i_n,
  output logic          o_last
);

  logic [CW-1:0] r_cnt;

  // Every phase is preceded by a cycle with i_run low, which reloads the count
  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_last = i_run && (r_cnt == (i_n - CW'(1)));

endmodule
`default_nettype wire

// File: rtl/game_draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : game_draw_sequencer                                               |
// | Brief  : Sequences clear/grid/level/number draw phases onto the VGA bus.   |
// |          Define REDRAW_QUEUE_EN to remember one redraw_req during a redraw.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module game_draw_sequencer
  import game_draw_pkg::*;
#(
  parameter int CLEAR_CYCLES = c_CLEAR_CYCLES,
  parameter int GRID_CYCLES  = c_GRID_CYCLES,
  parameter int NUM_CYCLES   = c_NUM_CYCLES,
  parameter int CW           = c_CW
) (
  input logic                  clk,
  input logic                  resetn,
  game_draw_sequencer_if.slave bus
);

  state_e        r_state;
  state_e        r_ret;
  level_e        r_lvl;
  logic [5:0]    r_en;
  logic          r_plot;
  logic          r_busy;
  logic [CW-1:0] w_n;
  logic          w_last;
  logic          w_take;

  always_comb begin
    w_n = CW'(NUM_CYCLES);
    if (r_state == S_CLR0 || r_state == S_CLR1) begin
      w_n = CW'(CLEAR_CYCLES);
    end else if (r_state == S_GRID) begin
      w_n = CW'(GRID_CYCLES);
    end
  end

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .rst    (resetn),
    .i_run  (r_plot),
    .i_n    (w_n),
    .o_last (w_last)
  );

`ifdef REDRAW_QUEUE_EN
  logic r_pend;
  logic w_play_gap;

  assign w_play_gap = (r_state == S_GAP) && (r_ret == S_PLAY);
  assign w_take     = w_play_gap && !bus.game_over && (r_pend || bus.redraw_req);

  always_ff @(posedge clk) begin
    if (resetn || bus.game_over || w_take) begin
      r_pend <= 1'b0;
    end else if (bus.redraw_req && (r_state == S_NUM || w_play_gap)) begin
      r_pend <= 1'b1;
    end
  end
`else
  assign w_take = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= S_CLR0;
      r_ret   <= S_GRID;
      r_lvl   <= LVL_NONE;
      r_en    <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_CLR0, S_CLR1, S_GRID, S_LVL, S_NUM: begin
          // S_CLR0 with clear low is the first cycle out of reset
          if (r_state == S_CLR0 && !r_en[c_EN_CLEAR]) begin
            r_en   <= draw_en(S_CLR0, r_lvl);
            r_plot <= 1'b1;
            r_busy <= 1'b1;
          end else if (w_last) begin
            r_state <= S_GAP;
            r_ret   <= after_phase(r_state);
            r_en    <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_GAP: begin
          if (bus.game_over && r_ret != S_GRID) begin
            r_state <= S_CLR1;
            r_en    <= draw_en(S_CLR1, r_lvl);
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_take) begin
            r_state <= S_NUM;
            r_en    <= draw_en(S_NUM, r_lvl);
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= r_ret;
            r_en    <= draw_en(r_ret, r_lvl);
            r_plot  <= (r_ret == S_GRID);
            r_busy  <= is_busy(r_ret);
          end
        end
        S_MENU: begin
          if (bus.game_over) begin
            r_state <= S_CLR1;
            r_en    <= draw_en(S_CLR1, r_lvl);
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (bus.level_valid && bus.level != 2'b00) begin
            r_state <= S_LVL;
            r_lvl   <= level_e'(bus.level);
            r_en    <= draw_en(S_LVL, level_e'(bus.level));
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.game_over) begin
            r_state <= S_CLR1;
            r_en    <= draw_en(S_CLR1, r_lvl);
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (bus.redraw_req) begin
            r_state <= S_NUM;
            r_en    <= draw_en(S_NUM, r_lvl);
            r_plot  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLR0;
          r_en    <= '0;
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drawGrid   = r_en[c_EN_GRID];
  assign bus.drawEZ     = r_en[c_EN_EZ];
  assign bus.drawNORMAL = r_en[c_EN_NORMAL];
  assign bus.drawHARD   = r_en[c_EN_HARD];
  assign bus.drawNum    = r_en[c_EN_NUM];
  assign bus.clear      = r_en[c_EN_CLEAR];
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.phase_done = w_last;

endmodule
`default_nettype wire

// File: tb/tb_game_draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_game_draw_sequencer                                            |
// | Brief  : Directed bench with a per-cycle schedule model of draw phases.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_game_draw_sequencer;

`ifdef REDRAW_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  localparam int NCLR = 8;
  localparam int NGRD = 4;
  localparam int NNUM = 4;

  localparam int M_BOOT = 0;
  localparam int M_MENU = 1;
  localparam int M_PLAY = 2;

  typedef struct packed {
    logic [5:0] en;
    logic       busy;
    logic       done;
    logic [7:0] tag;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  game_draw_sequencer_if bus ();

  game_draw_sequencer #(
    .CLEAR_CYCLES(NCLR),
    .GRID_CYCLES (NGRD),
    .NUM_CYCLES  (NNUM),
    .CW          (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  ent_t q[$];
  ent_t exp_e = '{en: 6'd0, busy: 1'b0, done: 1'b0, tag: "R"};
  int   mode = M_BOOT;
  bit   pend = 1'b0;
  bit   model_valid = 1'b0;
  int   run_len[6];
  int   last_len[6];
  int   bursts[6];
  int   dones = 0;

  // Schedule model: every accepted event appends whole phases to a cycle queue
  function automatic void push_phase(logic [5:0] en, int n, logic [7:0] tag);
    for (int i = 0; i < n; i++) q.push_back('{en: en, busy: 1'b1, done: (i == n - 1), tag: tag});
  endfunction

  function automatic void push_gap(logic [7:0] tag);
    q.push_back('{en: 6'd0, busy: 1'b1, done: 1'b0, tag: tag});
  endfunction

  function automatic void restart();
    push_phase(6'b100000, NCLR, "D");
    push_gap("x");
    push_phase(6'b000001, NGRD, "D");
    push_gap("G");
    mode = M_MENU;
  endfunction

  function automatic logic [5:0] lvl_en(logic [1:0] l);
    logic [5:0] v;
    v = '0;
    v[l] = 1'b1;
    return v;
  endfunction

  initial begin
    forever begin
      logic [7:0] cur;
      @(posedge clk);
      cur = exp_e.tag;
      if (resetn) begin
        q.delete();
        pend  = 1'b0;
        mode  = M_BOOT;
        exp_e = '{en: 6'd0, busy: 1'b0, done: 1'b0, tag: "R"};
      end else begin
        if (QUEUE) begin
          if (bus.game_over) pend = 1'b0;
          else if (bus.redraw_req && (cur == "N" || cur == "g")) pend = 1'b1;
        end
        if (q.size() == 0) begin
          if (mode == M_BOOT) begin
            restart();
          end else if (mode == M_MENU) begin
            if (bus.game_over) restart();
            else if (bus.level_valid && bus.level != 2'b00 && cur != "G") begin
              push_phase(lvl_en(bus.level), NNUM, "D");
              push_gap("g");
              mode = M_PLAY;
            end
          end else begin
            if (bus.game_over) restart();
            else if (pend || (bus.redraw_req && cur == "I")) begin
              pend = 1'b0;
              push_phase(6'b010000, NNUM, "N");
              push_gap("g");
            end
          end
        end
        if (q.size() != 0) exp_e = q.pop_front();
        else exp_e = '{en: 6'd0, busy: 1'b0, done: 1'b0, tag: "I"};
      end
      model_valid = 1'b1;
    end
  end

  initial begin
    for (int b = 0; b < 6; b++) begin
      run_len[b]  = 0;
      last_len[b] = 0;
      bursts[b]   = 0;
    end
    forever begin
      logic [5:0] act;
      @(negedge clk);
      act = {bus.clear, bus.drawNum, bus.drawHARD, bus.drawNORMAL, bus.drawEZ, bus.drawGrid};
      if (model_valid) begin
        vectors++;
        if (act !== exp_e.en || bus.plot !== (|exp_e.en) || bus.busy !== exp_e.busy ||
            bus.phase_done !== exp_e.done) begin
          miscompares++;
          $display("FAIL cycle_outputs t=%0t: en=%b plot=%b busy=%b done=%b, expected en=%b plot=%b busy=%b done=%b",
                   $time, act, bus.plot, bus.busy, bus.phase_done,
                   exp_e.en, |exp_e.en, exp_e.busy, exp_e.done);
        end
        vectors++;
        if ($countones(act) > 1 || bus.plot !== (|act)) begin
          miscompares++;
          $display("FAIL onehot_plot t=%0t: en=%b plot=%b, expected at most one enable and plot=OR",
                   $time, act, bus.plot);
        end
      end
      for (int b = 0; b < 6; b++) begin
        if (act[b]) run_len[b]++;
        else if (run_len[b] > 0) begin
          last_len[b] = run_len[b];
          bursts[b]++;
          run_len[b] = 0;
        end
      end
      if (bus.phase_done === 1'b1) dones++;
    end
  end

  task automatic check_lit(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_level(input logic [1:0] l);
    bus.level_valid = 1'b1;
    bus.level       = l;
    cyc(1);
    bus.level_valid = 1'b0;
    bus.level       = 2'b00;
  endtask

  task automatic pulse_redraw();
    bus.redraw_req = 1'b1;
    cyc(1);
    bus.redraw_req = 1'b0;
  endtask

  initial begin
    int d0, b0, k;
    resetn          = 1'b1;
    bus.level_valid = 1'b0;
    bus.level       = 2'b00;
    bus.redraw_req  = 1'b0;
    bus.game_over   = 1'b0;
    cyc(3);
    check_lit("reset_plot", bus.plot, 0);
    check_lit("reset_busy", bus.busy, 0);

    // Boot: clear 8, gap, grid 4, gap, menu
    resetn = 1'b0;
    cyc(16);
    check_lit("boot_clear_len", last_len[5], 8);
    check_lit("boot_grid_len", last_len[0], 4);
    check_lit("menu_busy", bus.busy, 0);

    // Invalid level ignored, then NORMAL
    pulse_level(2'b00);
    cyc(3);
    check_lit("lvl00_busy", bus.busy, 0);
    d0 = dones;
    b0 = bursts[2];
    pulse_level(2'b10);
    cyc(10);
    check_lit("normal_len", last_len[2], 4);
    check_lit("normal_bursts", bursts[2] - b0, 1);
    check_lit("normal_done_pulses", dones - d0, 1);

    // Redraw in play, then game_over beats a simultaneous redraw
    pulse_redraw();
    cyc(8);
    check_lit("num_len", last_len[4], 4);
    b0 = bursts[4];
    d0 = bursts[5];
    bus.redraw_req = 1'b1;
    bus.game_over  = 1'b1;
    cyc(1);
    bus.redraw_req = 1'b0;
    bus.game_over  = 1'b0;
    cyc(18);
    check_lit("gameover_no_num", bursts[4] - b0, 0);
    check_lit("gameover_clear_len", last_len[5], 8);
    check_lit("gameover_clear_bursts", bursts[5] - d0, 1);

    pulse_level(2'b11);
    cyc(8);

    // Redraw requests while a redraw is in progress
    b0 = bursts[4];
    pulse_redraw();
    cyc(2);
    pulse_redraw();
    pulse_redraw();
    cyc(16);
    check_lit("queued_num_bursts", bursts[4] - b0, QUEUE ? 2 : 1);

    // game_over during drawNum is honoured after the phase and its gap
    b0 = bursts[4];
    d0 = bursts[5];
    pulse_redraw();
    cyc(1);
    bus.game_over = 1'b1;
    cyc(10);
    bus.game_over = 1'b0;
    cyc(20);
    check_lit("late_gameover_num_len", last_len[4], 4);
    check_lit("late_gameover_clears", bursts[5] - d0, 1);

    // Reset in the third cycle of drawHARD
    pulse_level(2'b11);
    k = 0;
    while (bus.drawHARD !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    check_lit("hard_started", bus.drawHARD, 1);
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    check_lit("abort_plot", bus.plot, 0);
    check_lit("abort_hard_len", last_len[3], 3);
    resetn = 1'b0;
    cyc(16);
    check_lit("reboot_clear_len", last_len[5], 8);
    check_lit("reboot_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
